nes_controller_reader: RTL and testbench
========================================

// Module: nes_controller_reader
//
// PURPOSE
//   Host-side NES controller reader. It drives the shared latch/clock pins and
//   shifts in two serial, active-low button streams (controller 1 and 2) in
//   parallel. It presents debounced-by-frame 8-bit pressed masks that the
//   controller registers expose to the CPU. Typically triggered once per frame
//   (e.g. on vblank). Slave end of the link is the existing nes_controller model.
//
// PARAMETERS
//   LATCH_CYCLES  2  clk_1 cycles controller_latch is held high (>=1)
//   CLK_DIV       1  clk_1 cycles per half-period of controller_clk_out (>=1)
//
// PORTS
//   clk_1                     in   1  system/CPU clock; all logic on posedge
//   rst_n                     in   1  reset, synchronous, active-low
//   start                     in   1  request a read; sampled only in IDLE
//   controller_1_data_in_B    in   1  serial data ctrl 1, low = pressed
//   controller_2_data_in_B    in   1  serial data ctrl 2, low = pressed
//   controller_latch          out  1  parallel-load strobe to both pads
//   controller_clk_out        out  1  shift clock to both pads (rising = next bit)
//   controller_1_buttons_out  out  8  mapache64::data_t, 1 = pressed
//   controller_2_buttons_out  out  8  mapache64::data_t, 1 = pressed
//   buttons_valid             out  1  1-cycle pulse: *_buttons_out just updated
//   busy                      out  1  high in every state except IDLE
//
// BEHAVIOUR
//   - All outputs registered. Reset (rst_n=0 at posedge) applies at that edge,
//     including mid-read: state=IDLE, latch=0, clk_out=0, both buttons=8'h00,
//     valid=0, busy=0, counters/shift regs cleared.
//   - States:
//     - IDLE: start=1 -> LATCH.
//     - LATCH: latch=1, clk_out=0 for LATCH_CYCLES cycles -> LOW.
//     - LOW: clk_out=0 for CLK_DIV cycles. On its last cycle, sample both
//       data pins, invert them, and shift into per-pad shift regs. If 8 bits
//       are now taken -> DONE, else -> HIGH.
//     - HIGH: clk_out=1 for CLK_DIV cycles -> LOW.
//     - DONE: load both shift regs into *_buttons_out atomically,
//       buttons_valid=1 this cycle only -> IDLE.
//   - Bit map: first bit sampled (A) -> bit 7. Then B=6, Select=5, Start=4,
//     Up=3, Down=2, Left=1, Right=0.
//   - Exactly 7 rising edges of controller_clk_out per read; latch and clk_out
//     are never high together.
//   - Latency: buttons_valid high LATCH_CYCLES + 15*CLK_DIV + 1 cycles after
//     the edge that accepted start (defaults: 18).
//   - start while busy: ignored, no queueing. start held high: back-to-back
//     reads, period LATCH_CYCLES + 15*CLK_DIV + 2 cycles (defaults: 19).
//   - *_buttons_out hold their last value throughout a read; they change only
//     in DONE.
//   - Unplugged pad (data pulled high) reads 8'h00.
//   - Data pins are sampled directly with no synchronizer. The pads are clocked
//     by this block, so data is stable a full half-period before sampling.
//   - Counter widths: $clog2 of the max of LATCH_CYCLES and CLK_DIV, and a
//     3-bit bit counter. Counter wrap is impossible by construction.
//
// STRUCTURE
//   - mapache64 package:
//     - ControllerButtonA..ControllerButtonRight bit-index localparams (7..0).
//     - typedef enum nes_reader_state_t {IDLE, LATCH, LOW, HIGH, DONE}.
//     - NesLatchCycles and NesClkDiv defaults.
//   - Sub-module nes_shift_in, instantiated once per pad: 8-bit shift reg with
//     shift_en, serial active-low input, and parallel out. The FSM and counters
//     live in the top of this block.
//
// TESTING (bench uses two nes_controller models on latch/clk_out)
//   1. rst_n=0 for 2 cycles -> latch=0, clk_out=0, buttons 8'h00/8'h00,
//      valid=0, busy=0.
//   2. Pads pressed 8'h7F / 8'hFE, 1-cycle start -> latch high for 2 cycles,
//      7 clk_out rises, valid at +18. Buttons = 8'h7F / 8'hFE.
//   3. start re-pulsed at +5 and +10 during a read -> only one valid pulse,
//      7 clk rises, busy continuous.
//   4. start held high for 3 reads with pads changing between reads ->
//      valid at +18, +37, +56, each with the new values.
//   5. rst_n=0 during HIGH of bit 3 -> all outputs reset next edge, no valid.
//      A following start completes normally.
//   6. CLK_DIV=3, LATCH_CYCLES=4 -> clk_out halves of 3 cycles each, valid at
//      +50, values correct.

Source files
------------

// File: rtl/mapache64.sv
// Shared definitions for the mapache64 controller path: button bit positions,
// the reader state type and the default link timing.
package mapache64;

    typedef logic [7:0] data_t;

    // Position of each button in a pressed mask; the first serial bit is A.
    localparam int ControllerButtonA      = 7;
    localparam int ControllerButtonB      = 6;
    localparam int ControllerButtonSelect = 5;
    localparam int ControllerButtonStart  = 4;
    localparam int ControllerButtonUp     = 3;
    localparam int ControllerButtonDown   = 2;
    localparam int ControllerButtonLeft   = 1;
    localparam int ControllerButtonRight  = 0;

    // Default link timing in clk_1 cycles.
    localparam int NesLatchCycles = 2;
    localparam int NesClkDiv      = 1;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } nes_reader_state_t;

endpackage

// File: rtl/nes_shift_in.sv
// Per-pad serial capture: shifts in one active-low bit per enable, storing it
// as active-high so a fully shifted register is the pressed mask.
module nes_shift_in (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       shift_en_i,
    input  logic       data_in_b_i,
    output logic [7:0] data_o
);

    logic [7:0] shift_q;
    logic [7:0] shift_d;

    // Older bits move toward the MSB, so the first bit taken ends in bit 7.
    always_comb begin
        shift_d = shift_q;
        if (shift_en_i) begin
            shift_d = {shift_q[6:0], ~data_in_b_i};
        end
    end

    // Hold the captured bits, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign data_o = shift_q;

endmodule

// File: rtl/nes_controller_reader.sv
// Host-side NES controller reader: strobes the latch, generates the shift
// clock and captures both pads in parallel, publishing the pressed masks
// together with a one-cycle valid pulse at the end of each read.
module nes_controller_reader
    import mapache64::*;
#(
    parameter int LATCH_CYCLES = NesLatchCycles,
    parameter int CLK_DIV      = NesClkDiv
) (
    input  logic  clk_1,
    input  logic  rst_n,
    input  logic  start,
    input  logic  controller_1_data_in_B,
    input  logic  controller_2_data_in_B,
    output logic  controller_latch,
    output logic  controller_clk_out,
    output data_t controller_1_buttons_out,
    output data_t controller_2_buttons_out,
    output logic  buttons_valid,
    output logic  busy
);

    localparam int CntMax = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
    localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] LatchLast = CntW'(LATCH_CYCLES - 1);
    localparam logic [CntW-1:0] HalfLast  = CntW'(CLK_DIV - 1);

    nes_reader_state_t state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              latch_q, latch_d;
    logic              clk_out_q, clk_out_d;
    data_t             btn1_q, btn1_d;
    data_t             btn2_q, btn2_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              shift_en;
    data_t             shift1;
    data_t             shift2;

    nes_shift_in u_shift_1 (
        .clk_i       (clk_1),
        .rst_n_i     (rst_n),
        .shift_en_i  (shift_en),
        .data_in_b_i (controller_1_data_in_B),
        .data_o      (shift1)
    );

    nes_shift_in u_shift_2 (
        .clk_i       (clk_1),
        .rst_n_i     (rst_n),
        .shift_en_i  (shift_en),
        .data_in_b_i (controller_2_data_in_B),
        .data_o      (shift2)
    );

    // Next-state and next-output logic; pins are sampled on the last LOW cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        latch_d   = latch_q;
        clk_out_d = clk_out_q;
        btn1_d    = btn1_q;
        btn2_d    = btn2_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        shift_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LATCH;
                    latch_d   = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            LATCH: begin
                if (cnt_q == LatchLast) begin
                    state_d = LOW;
                    latch_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == HalfLast) begin
                    shift_en = 1'b1;
                    cnt_d    = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = HIGH;
                        clk_out_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == HalfLast) begin
                    state_d   = LOW;
                    clk_out_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                btn1_d  = shift1;
                btn2_d  = shift2;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register the FSM state, counters and every output; reset wins at any point.
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            latch_q   <= 1'b0;
            clk_out_q <= 1'b0;
            btn1_q    <= '0;
            btn2_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            latch_q   <= latch_d;
            clk_out_q <= clk_out_d;
            btn1_q    <= btn1_d;
            btn2_q    <= btn2_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign controller_latch         = latch_q;
    assign controller_clk_out       = clk_out_q;
    assign controller_1_buttons_out = btn1_q;
    assign controller_2_buttons_out = btn2_q;
    assign buttons_valid            = valid_q;
    assign busy                     = busy_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: two reader instances (default timing and a
// slow one), each talking to two behavioural NES pads.
module tb_nes_controller_reader;

    localparam int LA = 2;
    localparam int DA = 1;
    localparam int LB = 4;
    localparam int DB = 3;
    localparam int LatA = LA + 15 * DA + 1;
    localparam int LatB = LB + 15 * DB + 1;
    localparam int PeriodA = LA + 15 * DA + 2;

    logic clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    logic       rst_n;
    logic       startA, startB;
    logic       dA1, dA2, dB1, dB2;
    logic       latchA, clkA, validA, busyA;
    logic       latchB, clkB, validB, busyB;
    logic [7:0] btnA1, btnA2, btnB1, btnB2;

    int checks = 0;
    int failures = 0;

    nes_controller_reader #(.LATCH_CYCLES(LA), .CLK_DIV(DA)) dutA (
        .clk_1                    (clk_1),
        .rst_n                    (rst_n),
        .start                    (startA),
        .controller_1_data_in_B   (dA1),
        .controller_2_data_in_B   (dA2),
        .controller_latch         (latchA),
        .controller_clk_out       (clkA),
        .controller_1_buttons_out (btnA1),
        .controller_2_buttons_out (btnA2),
        .buttons_valid            (validA),
        .busy                     (busyA)
    );

    nes_controller_reader #(.LATCH_CYCLES(LB), .CLK_DIV(DB)) dutB (
        .clk_1                    (clk_1),
        .rst_n                    (rst_n),
        .start                    (startB),
        .controller_1_data_in_B   (dB1),
        .controller_2_data_in_B   (dB2),
        .controller_latch         (latchB),
        .controller_clk_out       (clkB),
        .controller_1_buttons_out (btnB1),
        .controller_2_buttons_out (btnB2),
        .buttons_valid            (validB),
        .busy                     (busyB)
    );

    // Behavioural pads: the latch snapshots the pressed mask and presents A,
    // each rising shift clock moves to the next button, and after the eighth
    // button (or when unplugged) the line idles high.
    logic [7:0] padA1 = '0, padA2 = '0, padB1 = '0, padB2 = '0;
    logic [7:0] snapA1 = '0, snapA2 = '0, snapB1 = '0, snapB2 = '0;
    logic       plugA2 = 1'b1;
    int         idxA = 8;
    int         idxB = 8;

    always @(posedge latchA) begin
        snapA1 = padA1;
        snapA2 = padA2;
        idxA   = 0;
    end

    always @(posedge clkA) if (idxA < 8) idxA++;

    always @(posedge latchB) begin
        snapB1 = padB1;
        snapB2 = padB2;
        idxB   = 0;
    end

    always @(posedge clkB) if (idxB < 8) idxB++;

    assign dA1 = (idxA < 8) ? ~snapA1[7 - idxA] : 1'b1;
    assign dA2 = (plugA2 && idxA < 8) ? ~snapA2[7 - idxA] : 1'b1;
    assign dB1 = (idxB < 8) ? ~snapB1[7 - idxB] : 1'b1;
    assign dB2 = (idxB < 8) ? ~snapB2[7 - idxB] : 1'b1;

    // Link monitors: shift-clock rises, valid pulses, latch width, latch/clock
    // overlap and the length of each high half of the slow shift clock.
    int risesA, risesB, validCntA, validCntB, latchCycA, latchCycB;
    int overlapA, overlapB, runB, runMinB, runMaxB;

    always @(posedge clkA) risesA++;
    always @(posedge clkB) risesB++;

    always @(negedge clk_1) begin
        if (validA === 1'b1) validCntA++;
        if (validB === 1'b1) validCntB++;
        if (latchA === 1'b1) latchCycA++;
        if (latchB === 1'b1) latchCycB++;
        if (latchA === 1'b1 && clkA === 1'b1) overlapA++;
        if (latchB === 1'b1 && clkB === 1'b1) overlapB++;
        if (clkB === 1'b1) begin
            runB++;
        end else if (runB != 0) begin
            if (runB < runMinB) runMinB = runB;
            if (runB > runMaxB) runMaxB = runB;
            runB = 0;
        end
    end

    task automatic resetCounters();
        risesA = 0; risesB = 0; validCntA = 0; validCntB = 0;
        latchCycA = 0; latchCycB = 0; overlapA = 0; overlapB = 0;
        runB = 0; runMinB = 1000; runMaxB = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // One read on the default-timing reader: pulse start, optionally re-pulse
    // it at two offsets, and wait (bounded) for valid while watching busy.
    task automatic applyStimulus(input int rep1, input int rep2, output int lat, output int busyDrops);
        startA = 1'b1;
        @(negedge clk_1);
        startA = 1'b0;
        lat = 0;
        busyDrops = 0;
        while (validA !== 1'b1 && lat < 200) begin
            if (busyA !== 1'b1) busyDrops++;
            @(negedge clk_1);
            lat++;
            startA = (validA !== 1'b1) && (lat == rep1 || lat == rep2);
        end
        startA = 1'b0;
    endtask

    int lat, drops, cyc, nValid, n;
    logic [7:0] exp1 [3];
    logic [7:0] exp2 [3];

    initial begin
        rst_n = 1'b0; startA = 1'b0; startB = 1'b0;
        resetCounters();
        $display("[TB] reset");
        repeat (2) @(negedge clk_1);
        checkOutput("rst_latch", 32'(latchA), 32'd0);
        checkOutput("rst_clk", 32'(clkA), 32'd0);
        checkOutput("rst_btn1", 32'(btnA1), 32'h00);
        checkOutput("rst_btn2", 32'(btnA2), 32'h00);
        checkOutput("rst_valid", 32'(validA), 32'd0);
        checkOutput("rst_busy", 32'(busyA), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_1);

        $display("[TB] single read 7F/FE");
        padA1 = 8'h7F; padA2 = 8'hFE;
        resetCounters();
        applyStimulus(-1, -1, lat, drops);
        checkOutput("t2_latency", 32'(lat), 32'(LatA));
        checkOutput("t2_btn1", 32'(btnA1), 32'h7F);
        checkOutput("t2_btn2", 32'(btnA2), 32'hFE);
        @(negedge clk_1);
        checkOutput("t2_valid_pulse", 32'(validA), 32'd0);
        checkOutput("t2_busy_idle", 32'(busyA), 32'd0);
        @(negedge clk_1);
        checkOutput("t2_rises", 32'(risesA), 32'd7);
        checkOutput("t2_latch_cycles", 32'(latchCycA), 32'(LA));
        checkOutput("t2_overlap", 32'(overlapA), 32'd0);
        checkOutput("t2_valid_count", 32'(validCntA), 32'd1);
        checkOutput("t2_busy_drops", 32'(drops), 32'd0);

        $display("[TB] start re-pulsed while busy");
        for (int r = 0; r < 3; r++) begin
            padA1 = (r == 0) ? 8'hFF : 8'($urandom);
            padA2 = (r == 0) ? 8'h00 : 8'($urandom);
            resetCounters();
            applyStimulus(5, 10, lat, drops);
            checkOutput("t3_latency", 32'(lat), 32'(LatA));
            checkOutput("t3_btn1", 32'(btnA1), 32'(padA1));
            checkOutput("t3_btn2", 32'(btnA2), 32'(padA2));
            checkOutput("t3_busy_drops", 32'(drops), 32'd0);
            repeat (25) @(negedge clk_1);
            checkOutput("t3_valid_count", 32'(validCntA), 32'd1);
            checkOutput("t3_rises", 32'(risesA), 32'd7);
        end

        $display("[TB] start held for three reads");
        resetCounters();
        padA1 = 8'($urandom); padA2 = 8'($urandom);
        exp1[0] = padA1; exp2[0] = padA2;
        startA = 1'b1;
        cyc = 0;
        nValid = 0;
        while (nValid < 3 && cyc < 100) begin
            @(negedge clk_1);
            cyc++;
            if (validA === 1'b1) begin
                checkOutput("t4_latency", 32'(cyc - 1), 32'(LatA + PeriodA * nValid));
                checkOutput("t4_btn1", 32'(btnA1), 32'(exp1[nValid]));
                checkOutput("t4_btn2", 32'(btnA2), 32'(exp2[nValid]));
                nValid++;
                if (nValid < 3) begin
                    padA1 = 8'($urandom); padA2 = 8'($urandom);
                    exp1[nValid] = padA1; exp2[nValid] = padA2;
                end else begin
                    startA = 1'b0;
                end
            end
        end
        startA = 1'b0;
        checkOutput("t4_reads_seen", 32'(nValid), 32'd3);
        repeat (25) @(negedge clk_1);
        checkOutput("t4_valid_count", 32'(validCntA), 32'd3);
        checkOutput("t4_rises", 32'(risesA), 32'd21);

        $display("[TB] reset in the middle of a read");
        padA1 = 8'($urandom) | 8'h01; padA2 = 8'($urandom) | 8'h80;
        resetCounters();
        startA = 1'b1;
        @(negedge clk_1);
        startA = 1'b0;
        n = 0;
        while (!(clkA === 1'b1 && risesA == 4) && n < 50) begin
            @(negedge clk_1);
            n++;
        end
        checkOutput("t5_reached_high", 32'(risesA), 32'd4);
        rst_n = 1'b0;
        @(negedge clk_1);
        checkOutput("t5_latch", 32'(latchA), 32'd0);
        checkOutput("t5_clk", 32'(clkA), 32'd0);
        checkOutput("t5_btn1", 32'(btnA1), 32'h00);
        checkOutput("t5_btn2", 32'(btnA2), 32'h00);
        checkOutput("t5_valid", 32'(validA), 32'd0);
        checkOutput("t5_busy", 32'(busyA), 32'd0);
        rst_n = 1'b1;
        repeat (25) @(negedge clk_1);
        checkOutput("t5_no_valid", 32'(validCntA), 32'd0);
        plugA2 = 1'b0;
        padA1 = 8'($urandom); padA2 = 8'hFF;
        resetCounters();
        applyStimulus(-1, -1, lat, drops);
        checkOutput("t5_after_latency", 32'(lat), 32'(LatA));
        checkOutput("t5_after_btn1", 32'(btnA1), 32'(padA1));
        checkOutput("t5_unplugged_btn2", 32'(btnA2), 32'h00);
        plugA2 = 1'b1;

        $display("[TB] slow link LATCH_CYCLES=4 CLK_DIV=3");
        padB1 = 8'($urandom); padB2 = 8'($urandom);
        resetCounters();
        startB = 1'b1;
        @(negedge clk_1);
        startB = 1'b0;
        lat = 0;
        while (validB !== 1'b1 && lat < 300) begin
            @(negedge clk_1);
            lat++;
        end
        checkOutput("t6_latency", 32'(lat), 32'(LatB));
        checkOutput("t6_btn1", 32'(btnB1), 32'(padB1));
        checkOutput("t6_btn2", 32'(btnB2), 32'(padB2));
        repeat (2) @(negedge clk_1);
        checkOutput("t6_rises", 32'(risesB), 32'd7);
        checkOutput("t6_latch_cycles", 32'(latchCycB), 32'(LB));
        checkOutput("t6_high_min", 32'(runMinB), 32'(DB));
        checkOutput("t6_high_max", 32'(runMaxB), 32'(DB));
        checkOutput("t6_overlap", 32'(overlapB), 32'd0);
        checkOutput("t6_valid_count", 32'(validCntB), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
